// File: rtl/tile_line_fetcher_if.sv
// Memory-side bus of the tile line fetcher: tile-map and pattern read ports.
// Both memories return rdata a fixed number of cycles after a 1-cycle rd pulse.
interface tile_line_fetcher_if #(
  parameter int MAP_AW = 13,
  parameter int PAT_AW = 11
);
  logic              map_rd;
  logic [MAP_AW-1:0] map_addr;
  logic [15:0]       map_rdata;
  logic              pat_rd;
  logic [PAT_AW-1:0] pat_addr;
  logic [15:0]       pat_rdata;

  modport master (
    output map_rd, map_addr, pat_rd, pat_addr,
    input  map_rdata, pat_rdata
  );

  modport slave (
    input  map_rd, map_addr, pat_rd, pat_addr,
    output map_rdata, pat_rdata
  );
endinterface

// File: rtl/tile_line_fetcher.sv
// Prefetches one scanline of 2bpp tiles into a ping-pong line buffer and streams
// per-pixel {palette, color_index} from the front half during active display.
module tile_line_fetcher #(
  parameter int H_ACTIVE      = 640,
  parameter int TILES_PER_ROW = 80,
  parameter int MAP_AW        = 13,
  parameter int PAT_AW        = 11,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                CLK_100,
  input  logic                RESET,
  input  logic                line_start,
  input  logic [9:0]          line_y,
  input  logic                pix_en,
  input  logic [9:0]          pix_x,
  tile_line_fetcher_if.master mem,
  output logic [2:0]          palette,
  output logic [1:0]          color_index,
  output logic                busy,
  output logic                overrun
);

  localparam int COL_W     = $clog2(TILES_PER_ROW);
  localparam int BUF_WORDS = 2 * TILES_PER_ROW;
  localparam int BUF_AW    = $clog2(BUF_WORDS);
  localparam int WAIT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int ENTRY_W   = 5;
  localparam int WORD_W    = 8 * ENTRY_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP_REQ,
    S_MAP_WAIT,
    S_PAT_REQ,
    S_PAT_WAIT,
    S_STORE
  } state_t;

  state_t            state_reg, state_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [7:0]        tile_reg, tile_next;
  logic [2:0]        tpal_reg, tpal_next;
  logic [15:0]       pat_reg, pat_next;
  logic [MAP_AW-1:0] row_base_reg;
  logic [2:0]        row_reg;
  logic              front_sel_reg;
  logic              front_valid_reg;
  logic              back_valid_reg;
  logic              overrun_reg;
  logic              store_en;
  logic              last_wait;
  logic              last_col;

  assign last_wait = (wait_reg == WAIT_W'(MEM_LATENCY - 1));
  assign last_col  = (col_reg == COL_W'(TILES_PER_ROW - 1));

  // ---------------------------------------------------------------- fetch FSM
  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      state_reg       <= S_IDLE;
      col_reg         <= '0;
      wait_reg        <= '0;
      front_sel_reg   <= 1'b0;
      front_valid_reg <= 1'b0;
      back_valid_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      wait_reg    <= wait_next;
      overrun_reg <= line_start && busy;
      if (line_start) begin
        front_sel_reg   <= ~front_sel_reg;
        front_valid_reg <= back_valid_reg;
        back_valid_reg  <= 1'b0;
      end else if (store_en && last_col) begin
        back_valid_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100) begin
    tile_reg <= tile_next;
    tpal_reg <= tpal_next;
    pat_reg  <= pat_next;
    if (line_start) begin
      row_base_reg <= MAP_AW'(line_y[9:3]) * MAP_AW'(TILES_PER_ROW);
      row_reg      <= line_y[2:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    wait_next  = wait_reg;
    tile_next  = tile_reg;
    tpal_next  = tpal_reg;
    pat_next   = pat_reg;
    store_en   = 1'b0;
    case (state_reg)
      S_IDLE: ;
      S_MAP_REQ: begin
        wait_next  = '0;
        state_next = S_MAP_WAIT;
      end
      S_MAP_WAIT: begin
        if (last_wait) begin
          tile_next  = mem.map_rdata[7:0];
          tpal_next  = mem.map_rdata[10:8];
          state_next = S_PAT_REQ;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_PAT_REQ: begin
        wait_next  = '0;
        state_next = S_PAT_WAIT;
      end
      S_PAT_WAIT: begin
        if (last_wait) begin
          pat_next   = mem.pat_rdata;
          state_next = S_STORE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_STORE: begin
        store_en = 1'b1;
        if (last_col) begin
          state_next = S_IDLE;
        end else begin
          col_next   = col_reg + 1'b1;
          state_next = S_MAP_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A new line restarts the fetch; a store landing now would hit the new front half.
    if (line_start) begin
      state_next = S_MAP_REQ;
      col_next   = '0;
      store_en   = 1'b0;
    end
  end

  assign mem.map_rd   = (state_reg == S_MAP_REQ) && !line_start;
  assign mem.map_addr = (state_reg == S_MAP_REQ) ? (row_base_reg + MAP_AW'(col_reg)) : '0;
  assign mem.pat_rd   = (state_reg == S_PAT_REQ) && !line_start;
  assign mem.pat_addr = (state_reg == S_PAT_REQ) ? PAT_AW'({tile_reg, row_reg}) : '0;
  assign busy         = (state_reg != S_IDLE);
  assign overrun      = overrun_reg;

  logic unused_map_bits;
  assign unused_map_bits = ^mem.map_rdata[15:11];

  // ---------------------------------------------------------------- line buffer
  // One word per tile holds its 8 pixel entries, so a tile is stored in a single write.
  logic [WORD_W-1:0]  line_buf [0:BUF_WORDS-1];
  logic [WORD_W-1:0]  wr_word;
  logic [WORD_W-1:0]  rd_word_reg;
  logic [BUF_AW-1:0]  wr_addr;
  logic [BUF_AW-1:0]  rd_addr;
  logic [COL_W-1:0]   rd_col;
  logic               pix_in_range;
  logic               pix_ok_reg;
  logic [2:0]         pix_sel_reg;
  logic [ENTRY_W-1:0] rd_entry [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_entry
      assign wr_word[gi*ENTRY_W +: ENTRY_W] = {tpal_reg, pat_reg[15-2*gi -: 2]};
      assign rd_entry[gi]                   = rd_word_reg[gi*ENTRY_W +: ENTRY_W];
    end
  endgenerate

  // Bank 0 occupies words [0, TILES_PER_ROW), bank 1 the words above it.
  assign wr_addr      = (front_sel_reg ? BUF_AW'(0) : BUF_AW'(TILES_PER_ROW)) + BUF_AW'(col_reg);
  assign pix_in_range = (pix_x < 10'(H_ACTIVE));
  assign rd_col       = pix_in_range ? COL_W'(pix_x[9:3]) : '0;
  assign rd_addr      = (front_sel_reg ? BUF_AW'(TILES_PER_ROW) : BUF_AW'(0)) + BUF_AW'(rd_col);

  always_ff @(posedge CLK_100) begin
    if (store_en) begin
      line_buf[wr_addr] <= wr_word;
    end
    if (pix_en) begin
      rd_word_reg <= line_buf[rd_addr];
    end
  end

  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      pix_ok_reg  <= 1'b0;
      pix_sel_reg <= '0;
    end else if (pix_en) begin
      pix_ok_reg  <= pix_in_range && front_valid_reg;
      pix_sel_reg <= pix_x[2:0];
    end
  end

  assign {palette, color_index} = pix_ok_reg ? rd_entry[pix_sel_reg] : '0;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Directed bench for tile_line_fetcher: latency-2 memory model, request recorder,
// and immediate-assertion checks of fetch addresses, timing, display and recovery.
`timescale 1ns/1ps
module tb_tile_line_fetcher;

  logic       CLK_100    = 1'b0;
  logic       RESET      = 1'b1;
  logic       line_start = 1'b0;
  logic [9:0] line_y     = '0;
  logic       pix_en     = 1'b0;
  logic [9:0] pix_x      = '0;
  logic [2:0] palette;
  logic [1:0] color_index;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int map_q[$];
  int map_c[$];
  int pat_q[$];
  int pat_c[$];

  tile_line_fetcher_if #(.MAP_AW(13), .PAT_AW(11)) bus ();

  tile_line_fetcher #(
    .H_ACTIVE(640), .TILES_PER_ROW(80), .MAP_AW(13), .PAT_AW(11), .MEM_LATENCY(2)
  ) dut (
    .CLK_100(CLK_100),
    .RESET(RESET),
    .line_start(line_start),
    .line_y(line_y),
    .pix_en(pix_en),
    .pix_x(pix_x),
    .mem(bus),
    .palette(palette),
    .color_index(color_index),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 CLK_100 = ~CLK_100;

  // Tile-map entry for column c of any row: palette = c%8, tile = c.
  function automatic logic [15:0] map_word(input int a);
    int c;
    c = a % 80;
    return {5'b0, 3'(c % 8), 8'(c)};
  endfunction

  // Memories with latency 2: data is only valid in the cycle it is due.
  logic        map_v1 = 1'b0, map_v2 = 1'b0, pat_v1 = 1'b0, pat_v2 = 1'b0;
  logic [15:0] map_d1 = '0, map_d2 = '0;
  always @(posedge CLK_100) begin
    cyc    <= cyc + 1;
    map_v1 <= bus.map_rd;
    map_d1 <= map_word(int'(bus.map_addr));
    map_v2 <= map_v1;
    map_d2 <= map_d1;
    pat_v1 <= bus.pat_rd;
    pat_v2 <= pat_v1;
  end
  assign bus.map_rdata = map_v2 ? map_d2 : 16'hFFFF;
  assign bus.pat_rdata = pat_v2 ? 16'h1B1B : 16'hFFFF;

  always @(negedge CLK_100) begin
    if (bus.map_rd) begin
      map_q.push_back(int'(bus.map_addr));
      map_c.push_back(cyc);
    end
    if (bus.pat_rd) begin
      pat_q.push_back(int'(bus.pat_addr));
      pat_c.push_back(cyc);
    end
    rd_cnt <= rd_cnt + int'(bus.map_rd) + int'(bus.pat_rd);
  end

  task automatic tick();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_line(input int y);
    line_y     = 10'(y);
    line_start = 1'b1;
    #1;
    chk("no_rd_in_line_start_cycle", 32'(bus.map_rd | bus.pat_rd), 32'd0);
    @(posedge CLK_100);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(output int hi);
    hi = 0;
    while (busy && hi < 1000) begin
      hi++;
      tick();
    end
    chk("fetch_completes", 32'(busy), 32'd0);
  endtask

  task automatic pix(input int x, input int pal, input int ci, input string tag);
    pix_x  = 10'(x);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk({tag, "_palette"}, 32'(palette), 32'(pal));
    chk({tag, "_color_index"}, 32'(color_index), 32'(ci));
  endtask

  initial begin
    int hi;
    int n0;
    int p0;
    int r0;
    int c0;

    // 1: reset
    tick();
    tick();
    chk("rst_map_rd", 32'(bus.map_rd), 32'd0);
    chk("rst_pat_rd", 32'(bus.pat_rd), 32'd0);
    chk("rst_map_addr", 32'(bus.map_addr), 32'd0);
    chk("rst_pat_addr", 32'(bus.pat_addr), 32'd0);
    chk("rst_palette", 32'(palette), 32'd0);
    chk("rst_color_index", 32'(color_index), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    RESET = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_no_rd", 32'(rd_cnt), 32'd0);

    // 2: fetch of line 11 (tile row 1)
    map_q.delete(); map_c.delete(); pat_q.delete(); pat_c.delete();
    start_line(11);
    chk("busy_rises", 32'(busy), 32'd1);
    wait_idle(hi);
    chk("busy_cycles_per_line", 32'(hi), 32'd560);
    chk("map_req_count", 32'(map_q.size()), 32'd80);
    chk("pat_req_count", 32'(pat_q.size()), 32'd80);
    for (int c = 0; c < 80; c++) begin
      chk($sformatf("map_addr_c%0d", c), 32'(map_q[c]), 32'(80 + c));
      chk($sformatf("pat_addr_c%0d", c), 32'(pat_q[c]), 32'(c * 8 + 3));
      chk($sformatf("tile_period_c%0d", c), 32'(map_c[c] - map_c[0]), 32'(7 * c));
      chk($sformatf("map_to_pat_c%0d", c), 32'(pat_c[c] - map_c[c]), 32'd3);
    end

    // 3: swap and display line 11 while line 19 is fetched
    start_line(19);
    pix(9, 1, 1, "x9");
    pix(15, 1, 3, "x15");
    pix(20, 2, 0, "x20");
    pix(26, 3, 2, "x26");
    pix(639, 7, 3, "x639");
    wait_idle(hi);

    // 4: overrun, the aborted buffer then displays zeros
    start_line(479);
    pix(9, 1, 1, "ovr_front_x9");
    repeat (98) tick();
    n0 = map_q.size();
    start_line(27);
    chk("overrun_pulse", 32'(overrun), 32'd1);
    tick();
    chk("overrun_clears", 32'(overrun), 32'd0);
    pix(9, 0, 0, "aborted_x9");
    pix(639, 0, 0, "aborted_x639");
    wait_idle(hi);
    chk("restart_map_addr", 32'(map_q[n0]), 32'd240);
    chk("restart_map_count", 32'(map_q.size() - n0), 32'd80);

    // 5: last tile of line 479, bounds and hold
    n0 = map_q.size();
    p0 = pat_q.size();
    start_line(479);
    pix(9, 1, 1, "recovered_x9");
    wait_idle(hi);
    chk("l479_map_count", 32'(map_q.size() - n0), 32'd80);
    chk("l479_last_map_addr", 32'(map_q[map_q.size() - 1]), 32'd4799);
    chk("l479_last_pat_addr", 32'(pat_q[pat_q.size() - 1]), 32'((79 << 3) | 7));
    chk("l479_pat_count", 32'(pat_q.size() - p0), 32'd80);
    start_line(11);
    c0 = cyc;
    pix(639, 7, 3, "l479_x639");
    pix(640, 0, 0, "x640");
    pix(15, 1, 3, "l479_x15");
    pix_x = 10'd640;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold_palette_%0d", i), 32'(palette), 32'd1);
      chk($sformatf("hold_color_index_%0d", i), 32'(color_index), 32'd3);
    end

    // 6: reset mid-fetch
    while (cyc - c0 < 199) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    r0 = rd_cnt;
    chk("midrst_map_rd", 32'(bus.map_rd), 32'd0);
    chk("midrst_pat_rd", 32'(bus.pat_rd), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_palette", 32'(palette), 32'd0);
    chk("midrst_color_index", 32'(color_index), 32'd0);
    repeat (50) tick();
    chk("midrst_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("midrst_still_idle", 32'(busy), 32'd0);
    start_line(11);
    pix(9, 0, 0, "postrst_invalid_x9");
    wait_idle(hi);
    start_line(19);
    pix(9, 1, 1, "postrst_valid_x9");
    pix(26, 3, 2, "postrst_valid_x26");
    wait_idle(hi);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
